decode_hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage CPU. It sits beside the decode stage and drives the decode-stage operand source selects (`D_rs1_sel`, `D_rs2_sel`: 0 = register file, 1 = W-stage write-back data). It also drives all stall and flush controls for load-use interlocks, multi-cycle mul/div occupancy of E, and taken-branch squashes. It keeps its own shadow copy of destination-register state for the E/M/W stages.

---
 rtl/cpu_ctrl_pkg.sv | 34 +++
 rtl/decode_hazard_ctrl_if.sv | 43 ++++
 rtl/md_occupancy_fsm.sv | 58 +++++
 rtl/decode_hazard_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the decode-stage hazard controller: register address
// width, mul/div occupancy states and the per-stage destination tags.
package cpu_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // Destination tag carried by the E slot (needs the load flag for interlocks).
  typedef struct packed {
    logic      we;
    reg_addr_t rd;
    logic      load;
  } stage_tag_t;

  // Destination tag for M and W, where only the write target matters.
  typedef struct packed {
    logic      we;
    reg_addr_t rd;
  } wb_tag_t;

  // A source hazards on a destination only if it is really read, is not x0,
  // and the destination is actually written.
  function automatic logic reg_match(input reg_addr_t rs, input logic used,
                                     input reg_addr_t rd, input logic we);
    return used && (rs != '0) && we && (rs == rd);
  endfunction

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// Decode-stage instruction fields in, forwarding selects and pipeline
// stall/flush controls out.
interface decode_hazard_ctrl_if;
  import cpu_ctrl_pkg::*;

  logic      D_valid;
  reg_addr_t D_rs1_addr;
  reg_addr_t D_rs2_addr;
  logic      D_rs1_used;
  logic      D_rs2_used;
  reg_addr_t D_rd_addr;
  logic      D_reg_write;
  logic      D_is_load;
  logic      D_is_muldiv;
  logic      E_branch_taken;

  logic      D_rs1_sel;
  logic      D_rs2_sel;
  logic      stall_F;
  logic      stall_D;
  logic      stall_E;
  logic      flush_D;
  logic      flush_E;
  logic      flush_M;
  logic      md_busy;

  // Pipeline side: drives decode fields, consumes controls.
  modport master (
    output D_valid, D_rs1_addr, D_rs2_addr, D_rs1_used, D_rs2_used,
           D_rd_addr, D_reg_write, D_is_load, D_is_muldiv, E_branch_taken,
    input  D_rs1_sel, D_rs2_sel, stall_F, stall_D, stall_E,
           flush_D, flush_E, flush_M, md_busy
  );

  // Hazard controller side.
  modport slave (
    input  D_valid, D_rs1_addr, D_rs2_addr, D_rs1_used, D_rs2_used,
           D_rd_addr, D_reg_write, D_is_load, D_is_muldiv, E_branch_taken,
    output D_rs1_sel, D_rs2_sel, stall_F, stall_D, stall_E,
           flush_D, flush_E, flush_M, md_busy
  );

endinterface

// File: rtl/md_occupancy_fsm.sv
// Tracks how long a mul/div instruction keeps E occupied. After start_i the
// block stays busy for MD_LAT-1 cycles; done_o marks the last busy cycle.
module md_occupancy_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic busy_o,
  output logic done_o
);

  localparam int              CNT_W    = $clog2(MD_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and counter registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: load the counter on start, count down while busy.
  // NOTE: defaults are assigned first so no path leaves a signal unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == BUSY);
  assign done_o = busy_o && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard controller: W-stage forwarding selects, load-use
// interlock, mul/div occupancy stalls and taken-branch squash. Keeps a shadow
// of the E/M/W destination tags so it needs nothing from the datapath.
module decode_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decode_hazard_ctrl_if.slave  hz
);

  stage_tag_t e_q, e_d;
  wb_tag_t    m_q, w_q;

  logic md_busy_w, md_done_w, md_start;
  logic load_use;
  logic rs1_sel, rs2_sel;
  logic stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, busy_out;
  logic unused_md_done;

  md_occupancy_fsm #(.MD_LAT(MD_LAT)) u_md_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (md_start),
    .busy_o  (md_busy_w),
    .done_o  (md_done_w)
  );

  // The last-cycle pulse is not needed by this controller.
  assign unused_md_done = md_done_w;

  // Forwarding from W is independent of any stall or flush decision.
  always_comb begin
    rs1_sel = reg_match(hz.D_rs1_addr, hz.D_rs1_used, w_q.rd, w_q.we);
    rs2_sel = reg_match(hz.D_rs2_addr, hz.D_rs2_used, w_q.rd, w_q.we);
  end

  // Prioritised control: mul/div occupancy, branch squash, load-use, advance.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_m  = 1'b0;
    busy_out = 1'b0;
    md_start = 1'b0;
    load_use = hz.D_valid && e_q.load &&
               (reg_match(hz.D_rs1_addr, hz.D_rs1_used, e_q.rd, e_q.we) ||
                reg_match(hz.D_rs2_addr, hz.D_rs2_used, e_q.rd, e_q.we));
    if (md_busy_w) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      stall_e  = 1'b1;
      flush_m  = 1'b1;
      busy_out = 1'b1;
    end else if (hz.E_branch_taken) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      md_start = hz.D_valid && hz.D_is_muldiv;
    end
  end

  // Tag entering E: a bubble on flush or empty decode; rd=0 never writes.
  always_comb begin
    e_d = '0;
    if (hz.D_valid && !flush_e) begin
      e_d.we   = hz.D_reg_write && (hz.D_rd_addr != '0);
      e_d.rd   = hz.D_rd_addr;
      e_d.load = hz.D_is_load;
    end
  end

  // Shadow pipeline shift; E holds and M takes a bubble while E is stalled.
  // NOTE: only tags are reset; all other state here is control, so a full
  // synchronous clear is cheap and makes the pipeline empty after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else if (stall_e) begin
      m_q <= '0;
      w_q <= m_q;
    end else begin
      e_q <= e_d;
      m_q <= '{we: e_q.we, rd: e_q.rd};
      w_q <= m_q;
    end
  end

  // Every control is forced low while reset is asserted.
  assign hz.D_rs1_sel = rst_n && rs1_sel;
  assign hz.D_rs2_sel = rst_n && rs2_sel;
  assign hz.stall_F   = rst_n && stall_f;
  assign hz.stall_D   = rst_n && stall_d;
  assign hz.stall_E   = rst_n && stall_e;
  assign hz.flush_D   = rst_n && flush_d;
  assign hz.flush_E   = rst_n && flush_e;
  assign hz.flush_M   = rst_n && flush_m;
  assign hz.md_busy   = rst_n && busy_out;

endmodule
